regs_shift_serializer: RTL

//  Parallel-in, serial-out shift register: the transmit side of the team's bitwise
//  (serial-in) shift register. Accepts an p_nbits word via val/rdy handshake, emits it
//  one bit per enabled cycle, MSB first, so a serial-in receiver shifting left rebuilds
//  the original word. Supports back-to-back words with no idle gap between them.

---
 rtl/regs_shift_serializer.sv | 57 +++++
 1 files changed

// File: rtl/regs_shift_serializer.sv
// regs_shift_serializer: parallel-in, serial-out shift register with val/rdy load, MSB first
module regs_shift_serializer #(
  parameter int   p_nbits    = 8,
  parameter logic p_idle_bit = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [p_nbits-1:0] recv_msg,
  input  logic               recv_val,
  output logic               recv_rdy,
  input  logic               en,
  output logic               q,
  output logic               q_val,
  output logic               last,
  output logic               busy
);
  localparam int CW = $clog2(p_nbits);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t             state_q, state_d;
  logic [p_nbits-1:0] sreg_q, sreg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               accept;
  // Outputs are forced quiet while reset is high, even before the reset edge lands.
  assign busy     = ~reset & (state_q == SHIFT);
  assign q_val    = busy;
  assign q        = q_val ? sreg_q[p_nbits-1] : p_idle_bit;
  assign last     = q_val & (cnt_q == CW'(p_nbits - 1));
  assign recv_rdy = ~reset & ((state_q == IDLE) | (last & en));
  assign accept   = recv_val & recv_rdy;
  // Next state: a load wins (also covers the zero-gap reload on last&en), else shift on en.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = SHIFT;
      sreg_d  = recv_msg;
      cnt_d   = '0;
    end else if (busy & en) begin
      state_d = last ? IDLE : SHIFT;
      sreg_d  = {sreg_q[p_nbits-2:0], 1'b0};
      cnt_d   = last ? '0 : cnt_q + 1'b1;
    end
  end
  // State registers with dominant synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
